// File: rtl/anton_neopixel_stream.sv
// anton_neopixel_stream: walks the raw pixel buffer and serialises each byte MSB-first as WS2812 NRZ.
// Build option `NEOPIXEL_STREAM_INVERT_EN inverts neoData (idle level 1) for an inverting level shifter.
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 511
`endif

module anton_neopixel_stream #(
  parameter int BUFFER_END   = `BUFFER_END_DEFAULT,
  parameter int T0H_CYCLES   = 3,
  parameter int T1H_CYCLES   = 6,
  parameter int BIT_CYCLES   = 10,
  parameter int RESET_CYCLES = 400,
  localparam int BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
  input  logic                   busClk,
  input  logic                   busRstn,
  output logic [BUFFER_BITS-1:0] pixelIxComb,
  input  logic [7:0]             pixelByte,
  input  logic [12:0]            regMax,
  input  logic                   regCtrlInit,
  input  logic                   regCtrlLimit,
  input  logic                   regCtrlRun,
  input  logic                   regCtrl32bit,
  output logic                   state,
  output logic                   streamSyncOf,
  output logic                   neoData
);

  localparam int CNT_BITS = $clog2(BIT_CYCLES);
  localparam int GAP_BITS = $clog2(RESET_CYCLES);
`ifdef NEOPIXEL_STREAM_INVERT_EN
  localparam logic LINE_IDLE = 1'b1;
`else
  localparam logic LINE_IDLE = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_RESET} fsm_t;

  fsm_t                   fsm_reg, fsm_next;
  logic [BUFFER_BITS-1:0] pixel_ix_reg, pixel_ix_next;
  logic [2:0]             bit_ix_reg, bit_ix_next;
  logic [CNT_BITS-1:0]    cycle_cnt_reg, cycle_cnt_next;
  logic [GAP_BITS-1:0]    gap_cnt_reg, gap_cnt_next;
  logic                   neo_reg, neo_next;
  logic                   sync_reg, sync_next;
  logic [BUFFER_BITS-1:0] last_ix;
  logic [BUFFER_BITS-1:0] step;
  logic                   cur_bit;
  logic                   bit_end;

  always_comb begin
    if (!regCtrlLimit) begin
      last_ix = BUFFER_BITS'(BUFFER_END);
    end else if (regCtrl32bit) begin
      last_ix = BUFFER_BITS'({regMax, 2'b10});
    end else begin
      last_ix = BUFFER_BITS'(regMax);
    end
  end

  // In 32-bit layout channel 3 is never transmitted, so channel 2 jumps straight to the next pixel.
  assign step    = (regCtrl32bit && pixel_ix_reg[1:0] == 2'd2) ? BUFFER_BITS'(2) : BUFFER_BITS'(1);
  assign cur_bit = pixelByte[bit_ix_reg];
  assign bit_end = (cycle_cnt_reg == CNT_BITS'(BIT_CYCLES - 1));

  always_comb begin
    fsm_next       = fsm_reg;
    pixel_ix_next  = pixel_ix_reg;
    bit_ix_next    = bit_ix_reg;
    cycle_cnt_next = cycle_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    neo_next       = 1'b0;
    if (regCtrlInit) begin
      fsm_next       = S_IDLE;
      pixel_ix_next  = '0;
      bit_ix_next    = 3'd7;
      cycle_cnt_next = '0;
      gap_cnt_next   = '0;
    end else begin
      case (fsm_reg)
        S_IDLE: begin
          if (regCtrlRun) begin
            fsm_next       = S_STREAM;
            pixel_ix_next  = '0;
            bit_ix_next    = 3'd7;
            cycle_cnt_next = '0;
          end
        end
        S_STREAM: begin
          neo_next = (cycle_cnt_reg < (cur_bit ? CNT_BITS'(T1H_CYCLES) : CNT_BITS'(T0H_CYCLES)));
          if (bit_end) begin
            cycle_cnt_next = '0;
            bit_ix_next    = bit_ix_reg - 3'd1;
            if (bit_ix_reg == 3'd0) begin
              if (pixel_ix_reg >= last_ix) begin
                pixel_ix_next = '0;
                gap_cnt_next  = '0;
                fsm_next      = S_RESET;
              end else begin
                pixel_ix_next = pixel_ix_reg + step;
              end
            end
          end else begin
            cycle_cnt_next = cycle_cnt_reg + CNT_BITS'(1);
          end
        end
        S_RESET: begin
          if (gap_cnt_reg == GAP_BITS'(RESET_CYCLES - 1)) begin
            gap_cnt_next = '0;
            fsm_next     = S_IDLE;
          end else begin
            gap_cnt_next = gap_cnt_reg + GAP_BITS'(1);
          end
        end
        default: fsm_next = S_IDLE;
      endcase
    end
    // Pulse is high during the final gap clock so the run bit is updated on the edge into IDLE.
    sync_next = (fsm_next == S_RESET) && (gap_cnt_next == GAP_BITS'(RESET_CYCLES - 1));
  end

  always_ff @(posedge busClk) begin
    if (!busRstn) begin
      fsm_reg       <= S_IDLE;
      pixel_ix_reg  <= '0;
      bit_ix_reg    <= 3'd7;
      cycle_cnt_reg <= '0;
      gap_cnt_reg   <= '0;
      neo_reg       <= LINE_IDLE;
      sync_reg      <= 1'b0;
    end else begin
      fsm_reg       <= fsm_next;
      pixel_ix_reg  <= pixel_ix_next;
      bit_ix_reg    <= bit_ix_next;
      cycle_cnt_reg <= cycle_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      neo_reg       <= neo_next ^ LINE_IDLE;
      sync_reg      <= sync_next;
    end
  end

  assign pixelIxComb  = pixel_ix_next;
  assign state        = (fsm_reg == S_STREAM);
  assign streamSyncOf = sync_reg;
  assign neoData      = neo_reg;

endmodule

// File: tb/tb_anton_neopixel_stream.sv
// Bench for anton_neopixel_stream: random frames checked cycle-by-cycle against a byte-order/NRZ model.
module tb_anton_neopixel_stream;
  localparam int BEND = 15;
  localparam int BB   = 4;
  localparam int BITC = 10;
  localparam int T0   = 3;
  localparam int T1   = 6;
  localparam int RST  = 400;
`ifdef NEOPIXEL_STREAM_INVERT_EN
  localparam logic IDLE_LVL = 1'b1;
`else
  localparam logic IDLE_LVL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic [BB-1:0] ix_comb;
  logic [7:0]    pix_byte;
  logic [12:0]   reg_max;
  logic          init, limit, run, b32;
  logic          st, sync, neo;
  logic [7:0]    ram [0:BEND];
  int            tests = 0;
  int            fails = 0;

  logic          cap_neo[$];
  logic          cap_st[$];
  logic          cap_sync[$];
  logic [BB-1:0] cap_ix[$];
  bit            cap_timeout;

  always #5 clk = ~clk;
  always @(posedge clk) pix_byte <= ram[ix_comb];

  anton_neopixel_stream #(
    .BUFFER_END(BEND), .T0H_CYCLES(T0), .T1H_CYCLES(T1), .BIT_CYCLES(BITC), .RESET_CYCLES(RST)
  ) dut (
    .busClk(clk), .busRstn(rstn), .pixelIxComb(ix_comb), .pixelByte(pix_byte),
    .regMax(reg_max), .regCtrlInit(init), .regCtrlLimit(limit), .regCtrlRun(run),
    .regCtrl32bit(b32), .state(st), .streamSyncOf(sync), .neoData(neo)
  );

  task automatic fill_ram();
    for (int i = 0; i <= BEND; i++) ram[i] = 8'($urandom);
  endtask

  // Pulses run, then samples every negedge (sample 0 = first STREAM cycle) until streamSyncOf.
  task automatic capture(input bit hold, input int act_at, input logic [12:0] act_max);
    cap_neo.delete(); cap_st.delete(); cap_sync.delete(); cap_ix.delete();
    cap_timeout = 1'b1;
    @(negedge clk); run = 1'b1;
    @(negedge clk);
    if (!hold) run = 1'b0;
    for (int j = 0; j < 4000; j++) begin
      if (j == act_at) reg_max = act_max;
      cap_neo.push_back(neo); cap_st.push_back(st);
      cap_sync.push_back(sync); cap_ix.push_back(ix_comb);
      if (sync === 1'b1) begin
        cap_timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stream(input string name, input bit lim, input logic [12:0] mx, input bit is32,
                             input bit hold, input int act_at, input logic [12:0] act_max);
    int addrs[$];
    int ix, lst, m, nb, bp, exp_ix;
    logic exp_neo, exp_st, exp_sync, b;
    limit = lim; reg_max = mx; b32 = is32;
    ix = 0;
    for (int k = 0; k < 64; k++) begin
      addrs.push_back(ix);
      m   = (act_at >= 0 && act_at <= (k + 1) * 8 * BITC - 1) ? int'(act_max) : int'(mx);
      lst = lim ? (is32 ? m * 4 + 2 : m) : BEND;
      lst = lst % (BEND + 1);
      if (ix >= lst) break;
      ix += (is32 && ix % 4 == 2) ? 2 : 1;
    end
    nb = addrs.size() * 8 * BITC;
    capture(hold, act_at, act_max);
    $display("[TB] %s: limit=%0d max=%0d 32bit=%0d bytes=%0d samples=%0d", name, lim, mx, is32,
             addrs.size(), cap_neo.size());
    tests++;
    if (cap_timeout || cap_neo.size() != nb + RST) begin
      fails++;
      $display("FAIL %s frame_length got=%0d timeout=%0d want=%0d", name, cap_neo.size(), cap_timeout, nb + RST);
    end else begin
      for (int j = 0; j < nb + RST; j++) begin
        if (j < nb) begin
          exp_st = 1'b1;
          if (j % 80 == 79) exp_ix = (j / 80 + 1 < addrs.size()) ? addrs[j / 80 + 1] : 0;
          else exp_ix = addrs[j / 80];
        end else begin
          exp_st = 1'b0;
          exp_ix = 0;
        end
        exp_neo = 1'b0;
        if (j >= 1 && j - 1 < nb) begin
          bp = j - 1;
          b  = ram[addrs[bp / 80]][7 - (bp % 80) / BITC];
          exp_neo = ((bp % BITC) < (b ? T1 : T0));
        end
        exp_neo  = exp_neo ^ IDLE_LVL;
        exp_sync = (j == nb + RST - 1);
        tests++;
        if (cap_neo[j] !== exp_neo) begin
          fails++; $display("FAIL %s neoData[%0d] got=%b want=%b", name, j, cap_neo[j], exp_neo);
        end
        tests++;
        if (cap_st[j] !== exp_st) begin
          fails++; $display("FAIL %s state[%0d] got=%b want=%b", name, j, cap_st[j], exp_st);
        end
        tests++;
        if (cap_sync[j] !== exp_sync) begin
          fails++; $display("FAIL %s sync[%0d] got=%b want=%b", name, j, cap_sync[j], exp_sync);
        end
        tests++;
        if (cap_ix[j] !== BB'(exp_ix)) begin
          fails++; $display("FAIL %s pixelIxComb[%0d] got=%0d want=%0d", name, j, cap_ix[j], exp_ix);
        end
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; run = 1'b1; init = 1'b0; limit = 1'b0; b32 = 1'b0; reg_max = '0;
    fill_ram();
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("[TB] reset: neo=%b state=%b sync=%b ix=%0d", neo, st, sync, ix_comb);
    tests++;
    if (neo !== IDLE_LVL) begin fails++; $display("FAIL reset_neo got=%b want=%b", neo, IDLE_LVL); end
    tests++;
    if (st !== 1'b0) begin fails++; $display("FAIL reset_state got=%b want=0", st); end
    tests++;
    if (sync !== 1'b0) begin fails++; $display("FAIL reset_sync got=%b want=0", sync); end
    tests++;
    if (ix_comb !== '0) begin fails++; $display("FAIL reset_ix got=%0d want=0", ix_comb); end
    run = 1'b0;
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_a5();
    fill_ram(); ram[0] = 8'hA5;
    test_stream("a5_single_byte", 1'b1, 13'd0, 1'b0, 1'b0, -1, 13'd0);
  endtask

  task automatic test_32bit();
    fill_ram();
    test_stream("skip_channel3", 1'b1, 13'd1, 1'b1, 1'b0, -1, 13'd0);
  endtask

  task automatic test_random();
    bit is32;
    for (int n = 0; n < 4; n++) begin
      fill_ram();
      is32 = 1'($urandom_range(0, 1));
      test_stream("random_frame", 1'b1, 13'($urandom_range(0, 3)), is32, 1'b0, -1, 13'd0);
    end
  endtask

  task automatic test_full_buffer();
    fill_ram();
    test_stream("full_buffer", 1'b0, 13'($urandom_range(0, 3)), 1'b0, 1'b0, -1, 13'd0);
  endtask

  task automatic test_limit_change();
    fill_ram();
    test_stream("limit_lowered", 1'b1, 13'd5, 1'b0, 1'b0, 200, 13'd1);
  endtask

  task automatic test_back_to_back();
    int waited;
    fill_ram();
    limit = 1'b1; reg_max = 13'd0; b32 = 1'b0;
    capture(1'b1, -1, 13'd0);
    tests++;
    if (cap_timeout) begin fails++; $display("FAIL b2b first_sync got=timeout want=pulse"); end
    @(negedge clk);
    tests++;
    if (st !== 1'b0) begin fails++; $display("FAIL b2b idle_after_sync got=%b want=0", st); end
    @(negedge clk);
    $display("[TB] back_to_back: restart state=%b ix=%0d", st, ix_comb);
    tests++;
    if (st !== 1'b1) begin fails++; $display("FAIL b2b restart_state got=%b want=1", st); end
    tests++;
    if (ix_comb !== '0) begin fails++; $display("FAIL b2b restart_ix got=%0d want=0", ix_comb); end
    waited = 0;
    while (sync !== 1'b1 && waited < 2000) begin
      @(negedge clk); waited++;
    end
    tests++;
    if (waited >= 2000) begin fails++; $display("FAIL b2b second_sync got=timeout want=pulse"); end
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (st !== 1'b0 || neo !== IDLE_LVL) begin
        fails++; $display("FAIL b2b stay_idle got=state%b/neo%b want=state0/neo%b", st, neo, IDLE_LVL);
      end
    end
  endtask

  task automatic test_init();
    int n_sync, n_st;
    fill_ram();
    limit = 1'b1; reg_max = 13'd5; b32 = 1'b0;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    repeat (114) @(negedge clk);
    tests++;
    if (st !== 1'b1) begin fails++; $display("FAIL init_precondition state got=%b want=1", st); end
    init = 1'b1;
    @(negedge clk);
    tests++;
    if (st !== 1'b0) begin fails++; $display("FAIL init_state got=%b want=0", st); end
    tests++;
    if (neo !== IDLE_LVL) begin fails++; $display("FAIL init_neo got=%b want=%b", neo, IDLE_LVL); end
    tests++;
    if (sync !== 1'b0) begin fails++; $display("FAIL init_sync got=%b want=0", sync); end
    init = 1'b0;
    #1;
    tests++;
    if (ix_comb !== '0) begin fails++; $display("FAIL init_pixel_ix got=%0d want=0", ix_comb); end
    n_sync = 0; n_st = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (sync === 1'b1) n_sync++;
      if (st === 1'b1) n_st++;
    end
    $display("[TB] init_abort: sync_pulses=%0d stream_clocks=%0d", n_sync, n_st);
    tests++;
    if (n_sync != 0) begin fails++; $display("FAIL init_no_sync got=%0d want=0", n_sync); end
    tests++;
    if (n_st != 0) begin fails++; $display("FAIL init_stays_idle got=%0d want=0", n_st); end
  endtask

  initial begin
    test_reset();
    test_a5();
    test_32bit();
    test_random();
    test_full_buffer();
    test_limit_change();
    test_back_to_back();
    test_init();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
